// File: rtl/cdb_arbiter_pkg.sv
// Shared Common Data Bus definitions: station codes, "no value" marker and the
// round-robin pointer encoding used by the arbiter, dispatch and reservation stations.
package cdb_arbiter_pkg;

  localparam int unsigned DataW = 16;
  localparam int unsigned RegW  = 4;
  localparam int unsigned TagW  = 3;

  localparam logic [TagW-1:0] FREE_REGISTER    = 3'd0;
  localparam logic [TagW-1:0] RES_STATION_ADD1 = 3'd1;
  localparam logic [TagW-1:0] RES_STATION_ADD2 = 3'd2;
  localparam logic [TagW-1:0] RES_STATION_MUL1 = 3'd3;

  localparam logic [TagW-1:0]  NO_STATION = FREE_REGISTER;
  localparam logic [DataW-1:0] NO_VALUE   = 16'hFFF0;

  // Requester bit positions in the request/grant vectors.
  localparam int unsigned IdxAdd1 = 0;
  localparam int unsigned IdxAdd2 = 1;
  localparam int unsigned IdxMul1 = 2;

  // Last-grant pointer; the search starts at the requester after it.
  typedef enum logic [1:0] {
    PtrAdd1 = 2'd0,
    PtrAdd2 = 2'd1,
    PtrMul1 = 2'd2
  } rr_ptr_e;

  function automatic logic [TagW-1:0] station_code(input logic [2:0] onehot);
    logic [TagW-1:0] code;
    code = NO_STATION;
    case (onehot)
      3'b001:  code = RES_STATION_ADD1;
      3'b010:  code = RES_STATION_ADD2;
      3'b100:  code = RES_STATION_MUL1;
      default: code = NO_STATION;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational three-way round-robin selector: picks the first eligible
// requester after the last-granted one, ADD1 -> ADD2 -> MUL1 -> ADD1.
module rr_picker
  import cdb_arbiter_pkg::*;
(
  input  logic [2:0] eligible_i,
  input  rr_ptr_e    ptr_i,
  output logic [2:0] winner_o,
  output logic       any_o
);

  logic e_add1, e_add2, e_mul1;

  assign e_add1 = eligible_i[IdxAdd1];
  assign e_add2 = eligible_i[IdxAdd2];
  assign e_mul1 = eligible_i[IdxMul1];
  assign any_o  = |eligible_i;

  always_comb begin
    winner_o = 3'b000;
    unique case (ptr_i)
      PtrAdd1: begin
        if (e_add2)      winner_o = 3'b010;
        else if (e_mul1) winner_o = 3'b100;
        else if (e_add1) winner_o = 3'b001;
      end
      PtrAdd2: begin
        if (e_mul1)      winner_o = 3'b100;
        else if (e_add1) winner_o = 3'b001;
        else if (e_add2) winner_o = 3'b010;
      end
      // PtrMul1, and the unused encoding recovers as if MUL1 was last.
      default: begin
        if (e_add1)      winner_o = 3'b001;
        else if (e_add2) winner_o = 3'b010;
        else if (e_mul1) winner_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: registers one round-robin winner per cycle onto the
// CDB and counts cycles in which a request had to wait.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req_ADD1,
  input  logic             Req_ADD2,
  input  logic             Req_MUL1,
  input  logic [DataW-1:0] Data_ADD1,
  input  logic [DataW-1:0] Data_ADD2,
  input  logic [DataW-1:0] Data_MUL1,
  input  logic [RegW-1:0]  Rtarget_ADD1,
  input  logic [RegW-1:0]  Rtarget_ADD2,
  input  logic [RegW-1:0]  Rtarget_MUL1,
  output logic             Grant_ADD1,
  output logic             Grant_ADD2,
  output logic             Grant_MUL1,
  output logic             CDB_valid,
  output logic [TagW-1:0]  CDB_tag,
  output logic [DataW-1:0] CDB_data,
  output logic [RegW-1:0]  CDB_R_target,
  output logic [7:0]       Conflict_count
);

  logic [2:0]       req;
  logic [2:0]       eligible;
  logic [2:0]       winner;
  logic             any_req;
  logic             multi_req;

  logic [2:0]       grant_q, grant_d;
  rr_ptr_e          ptr_q, ptr_d;
  logic [TagW-1:0]  tag_q, tag_d;
  logic [DataW-1:0] data_q, data_d;
  logic [RegW-1:0]  rtgt_q, rtgt_d;
  logic [7:0]       cnt_q, cnt_d;

  assign req = {Req_MUL1, Req_ADD2, Req_ADD1};
  // A requester on the bus this cycle has already been served.
  assign eligible = req & ~grant_q;

  assign multi_req = (eligible[0] & eligible[1]) | (eligible[0] & eligible[2]) |
                     (eligible[1] & eligible[2]);

  rr_picker u_rr_picker (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .winner_o   (winner),
    .any_o      (any_req)
  );

  always_comb begin
    grant_d = winner;
    tag_d   = station_code(winner);
    data_d  = NO_VALUE;
    rtgt_d  = '0;
    ptr_d   = ptr_q;
    unique case (winner)
      3'b001: begin
        data_d = Data_ADD1;
        rtgt_d = Rtarget_ADD1;
        ptr_d  = PtrAdd1;
      end
      3'b010: begin
        data_d = Data_ADD2;
        rtgt_d = Rtarget_ADD2;
        ptr_d  = PtrAdd2;
      end
      3'b100: begin
        data_d = Data_MUL1;
        rtgt_d = Rtarget_MUL1;
        ptr_d  = PtrMul1;
      end
      default: begin
        grant_d = 3'b000;
        tag_d   = NO_STATION;
      end
    endcase
    if (!any_req) begin
      ptr_d = ptr_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (multi_req && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      grant_q <= 3'b000;
      ptr_q   <= PtrMul1;
      tag_q   <= NO_STATION;
      data_q  <= NO_VALUE;
      rtgt_q  <= '0;
      cnt_q   <= 8'h00;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      rtgt_q  <= rtgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Grant_ADD1     = grant_q[IdxAdd1];
  assign Grant_ADD2     = grant_q[IdxAdd2];
  assign Grant_MUL1     = grant_q[IdxMul1];
  assign CDB_valid      = |grant_q;
  assign CDB_tag        = tag_q;
  assign CDB_data       = data_q;
  assign CDB_R_target   = rtgt_q;
  assign Conflict_count = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Req_ADD1, Req_ADD2, Req_MUL1;
  logic [15:0] Data_ADD1, Data_ADD2, Data_MUL1;
  logic [3:0]  Rtarget_ADD1, Rtarget_ADD2, Rtarget_MUL1;
  logic        Grant_ADD1, Grant_ADD2, Grant_MUL1;
  logic        CDB_valid;
  logic [2:0]  CDB_tag;
  logic [15:0] CDB_data;
  logic [3:0]  CDB_R_target;
  logic [7:0]  Conflict_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  cdb_arbiter dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Req_ADD1       (Req_ADD1),
    .Req_ADD2       (Req_ADD2),
    .Req_MUL1       (Req_MUL1),
    .Data_ADD1      (Data_ADD1),
    .Data_ADD2      (Data_ADD2),
    .Data_MUL1      (Data_MUL1),
    .Rtarget_ADD1   (Rtarget_ADD1),
    .Rtarget_ADD2   (Rtarget_ADD2),
    .Rtarget_MUL1   (Rtarget_MUL1),
    .Grant_ADD1     (Grant_ADD1),
    .Grant_ADD2     (Grant_ADD2),
    .Grant_MUL1     (Grant_MUL1),
    .CDB_valid      (CDB_valid),
    .CDB_tag        (CDB_tag),
    .CDB_data       (CDB_data),
    .CDB_R_target   (CDB_R_target),
    .Conflict_count (Conflict_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    Req_ADD1 = 0; Req_ADD2 = 0; Req_MUL1 = 0;
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  // Grants as {MUL1, ADD2, ADD1}.
  function automatic logic [2:0] grants();
    return {Grant_MUL1, Grant_ADD2, Grant_ADD1};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, {29'd0, grants()}, 32'd0);
    check({tag, "_valid"}, {31'd0, CDB_valid}, 32'd0);
    check({tag, "_tag"},   {29'd0, CDB_tag}, 32'd0);
    check({tag, "_data"},  {16'd0, CDB_data}, 32'hFFF0);
    check({tag, "_rtgt"},  {28'd0, CDB_R_target}, 32'd0);
  endtask

  initial begin
    Reset = 1'b0;
    Req_ADD1 = 0; Req_ADD2 = 0; Req_MUL1 = 0;
    Data_ADD1 = 16'h0005; Data_ADD2 = 16'h0A0A; Data_MUL1 = 16'h0C0C;
    Rtarget_ADD1 = 4'd2; Rtarget_ADD2 = 4'd5; Rtarget_MUL1 = 4'd9;
    step();

    // Reset state and single ADD1 request.
    apply_reset();
    check_idle("rst");
    check("rst_cnt", {24'd0, Conflict_count}, 32'd0);
    Req_ADD1 = 1;
    step();
    check("single_grant", {29'd0, grants()}, 32'b001);
    check("single_valid", {31'd0, CDB_valid}, 32'd1);
    check("single_tag",   {29'd0, CDB_tag}, 32'd1);
    check("single_data",  {16'd0, CDB_data}, 32'h0005);
    check("single_rtgt",  {28'd0, CDB_R_target}, 32'd2);
    Req_ADD1 = 0;
    step();
    check_idle("single_after");

    // All three request from reset, each drops after its grant.
    apply_reset();
    Req_ADD1 = 1; Req_ADD2 = 1; Req_MUL1 = 1;
    step();
    check("all3_g1", {29'd0, grants()}, 32'b001);
    check("all3_c1", {24'd0, Conflict_count}, 32'd1);
    step();
    Req_ADD1 = 0;
    check("all3_g2",    {29'd0, grants()}, 32'b010);
    check("all3_tag2",  {29'd0, CDB_tag}, 32'd2);
    check("all3_data2", {16'd0, CDB_data}, 32'h0A0A);
    check("all3_rtgt2", {28'd0, CDB_R_target}, 32'd5);
    step();
    Req_ADD2 = 0;
    check("all3_g3",    {29'd0, grants()}, 32'b100);
    check("all3_tag3",  {29'd0, CDB_tag}, 32'd3);
    check("all3_data3", {16'd0, CDB_data}, 32'h0C0C);
    step();
    Req_MUL1 = 0;
    check_idle("all3_end");
    check("all3_cnt", {24'd0, Conflict_count}, 32'd2);

    // ADD1 and ADD2 held continuously: strict alternation.
    apply_reset();
    Req_ADD1 = 1; Req_ADD2 = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("alt_grant", {29'd0, grants()}, (i % 2 == 0) ? 32'b001 : 32'b010);
    end
    check("alt_cnt", {24'd0, Conflict_count}, 32'd1);
    Req_ADD1 = 0; Req_ADD2 = 0;
    step();

    // Reset pulsed during a MUL1 grant cycle.
    apply_reset();
    Req_MUL1 = 1;
    step();
    check("rstmid_pre", {29'd0, grants()}, 32'b100);
    Reset = 1'b1;
    #1;
    check("rstmid_grant", {29'd0, grants()}, 32'd0);
    check("rstmid_valid", {31'd0, CDB_valid}, 32'd0);
    check("rstmid_tag",   {29'd0, CDB_tag}, 32'd0);
    Reset = 1'b0;
    Req_MUL1 = 0;
    Req_ADD2 = 1; Data_ADD2 = 16'h1234; Rtarget_ADD2 = 4'd7;
    step();
    check("rstmid_add2",  {29'd0, grants()}, 32'b010);
    check("rstmid_tag2",  {29'd0, CDB_tag}, 32'd2);
    check("rstmid_data2", {16'd0, CDB_data}, 32'h1234);
    check("rstmid_rtgt2", {28'd0, CDB_R_target}, 32'd7);
    Req_ADD2 = 0;
    step();

    // 260 conflict edges: rotation, one-hot grants, saturation.
    apply_reset();
    Req_ADD1 = 1; Req_ADD2 = 1; Req_MUL1 = 1;
    for (int i = 0; i < 260; i++) begin
      step();
      check("sat_grant",  {29'd0, grants()}, 32'd1 << (i % 3));
      check("sat_onehot", $countones(grants()), 32'd1);
      check("sat_valid",  {31'd0, CDB_valid}, {31'd0, |grants()});
      if (i == 99) check("sat_cnt100", {24'd0, Conflict_count}, 32'd100);
    end
    check("sat_cnt", {24'd0, Conflict_count}, 32'hFF);
    Req_ADD1 = 0; Req_ADD2 = 0; Req_MUL1 = 0;
    step();
    step();
    check_idle("sat_end");
    check("sat_hold", {24'd0, Conflict_count}, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Clock  input  1  single system clock; all state changes on posedge Clock.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 Req_ADD1, Req_ADD2, Req_MUL1  input  1 each  request from the unit to broadcast a finished result on the CDB.
REQ-004 Data_ADD1, Data_ADD2, Data_MUL1  input  16 each  result value; stable while the matching Req is high.
REQ-005 Rtarget_ADD1, Rtarget_ADD2, Rtarget_MUL1  input  4 each  destination register of the result.
REQ-006 Grant_ADD1, Grant_ADD2, Grant_MUL1  output  1 each  one-cycle pulse: this unit's result is on the CDB this cycle.
REQ-007 CDB_valid  output  1  CDB carries a result this cycle.
REQ-008 CDB_tag  output  3  reservation-station code of the producer: 1 = ADD1, 2 = ADD2, 3 = MUL1, 0 = none.
REQ-009 CDB_data  output  16  broadcast value.
REQ-010 CDB_R_target  output  4  broadcast destination register.
REQ-011 Conflict_count  output  8  saturating count of cycles in which at least one request was left ungranted.

Function
REQ-012 The block SHALL arbitrate the single Common Data Bus among three requesters using round-robin priority on a 2-bit last-grant pointer.
- Search order starts at the requester after the last one granted: ADD1 -> ADD2 -> MUL1 -> ADD1.
REQ-013 At each posedge with at least one eligible request, the block SHALL register exactly one winner.
- For that winner, in the following cycle: its Grant = 1, CDB_valid = 1, CDB_tag = its code, CDB_data / CDB_R_target = its Data / Rtarget as sampled at that edge.
- The pointer updates to that winner at the same edge.
REQ-014 Latency SHALL be one cycle: Req sampled high at edge N gives Grant and CDB outputs high during the cycle after edge N, provided that requester wins.
REQ-015 A requester whose Grant is high in the current cycle SHALL be ineligible at the next edge even if its Req is still high; its Req is treated as already consumed.
REQ-016 Requesters SHALL deassert Req at the edge ending their Grant cycle. A Req still high one cycle later SHALL be treated as a new request.
REQ-017 With no eligible request at an edge:
- all Grants = 0, CDB_valid = 0, CDB_tag = 3'b000, CDB_data = 16'hFFF0, CDB_R_target = 4'b0000;
- the pointer holds.
REQ-018 Back-to-back grants to different requesters on consecutive cycles SHALL be supported with no idle cycle between them.
REQ-019 At most one Grant SHALL be high in any cycle, and CDB_valid SHALL equal the OR of the Grants.
REQ-020 Conflict_count SHALL increment by 1 at each edge where the number of eligible requests is 2 or more, and saturate at 8'hFF.
REQ-021 Starvation bound: a request held continuously SHALL be granted within 3 arbitration edges.
REQ-022 Internal state is limited to: pointer, registered Grants, registered CDB fields, and Conflict_count. The block has no further FSM states.

Reset
REQ-023 Reset SHALL force, asynchronously:
- all Grants = 0, CDB_valid = 0, CDB_tag = 3'b000, CDB_data = 16'hFFF0, CDB_R_target = 4'b0000, Conflict_count = 8'h00;
- pointer = MUL1, so ADD1 has first priority.
REQ-024 A Reset asserted during a Grant cycle SHALL drop the Grant in the same cycle. The result is lost, and the requester re-requests after reset.

Structure
REQ-025 A shared package SHALL hold the station codes, the "no value" constant 16'hFFF0, and the "no station" code 3'b000.
- Station codes: FREE_REGISTER = 0, RES_STATION_ADD1 = 1, RES_STATION_ADD2 = 2, RES_STATION_MUL1 = 3.
- The dispatch unit and the reservation stations SHALL use the same package.
REQ-026 The combinational round-robin selection SHALL live in one sub-module, rr_picker.
- Inputs: eligible vector [2:0] and pointer.
- Outputs: one-hot winner [2:0] and an any-request flag.
- All registers stay in cdb_arbiter.

Verification
REQ-027 After reset, Req_ADD1 = 1 only, Data_ADD1 = 16'h0005, Rtarget_ADD1 = 4'd2 -> next cycle: Grant_ADD1 = 1, CDB_tag = 1, CDB_data = 16'h0005, CDB_R_target = 2; the cycle after, Req dropped -> CDB_valid = 0, CDB_data = 16'hFFF0.
REQ-028 All three Req high from reset and each dropped after its Grant -> grants ADD1, ADD2, MUL1 on three consecutive cycles; Conflict_count = 2.
REQ-029 Req_ADD1 and Req_ADD2 held high continuously for 6 cycles, with the requester ignoring the Grant -> grants alternate ADD1, ADD2, ADD1, ...; never the same unit twice in a row.
REQ-030 Reset pulsed during a Grant_MUL1 cycle -> Grant_MUL1, CDB_valid and CDB_tag = 0 immediately; the next request from ADD2 alone is granted one cycle after it is sampled.
REQ-031 Force 260 conflict edges -> Conflict_count stops at 8'hFF; a one-hot check on the Grants passes every cycle.
